cmos_crop_packer: RTL and testbench

- Sits directly downstream of the OV5640 byte-to-RGB565 assembler, in the cmos_pclk domain.
- Tracks pixel x/y position from the assembled pixel stream and the camera sync signals, and keeps only pixels inside a parameterised crop window.
- Packs two RGB565 pixels into one 32-bit word and writes each word into the async pixel FIFO toward the frame buffer.
- Flags start-of-frame, end-of-line and FIFO overflow.

---
 rtl/cmos_crop_packer_if.sv | 27 ++
 rtl/cmos_crop_packer.sv | 178 +++++++++++++++++
 tb/tb_cmos_crop_packer.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmos_crop_packer_if.sv
// Pixel-in / FIFO-write bundle for cmos_crop_packer.
// master: the packer (consumes sync/pixels, drives FIFO writes and status).
// slave:  the camera/FIFO side.
interface cmos_crop_packer_if;
   logic        cmos_vsync;
   logic        cmos_href;
   logic [15:0] rgb565;
   logic        rgb565_ready;
   logic        fifo_full;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        sof;
   logic        eol;
   logic        frame_done;
   logic        overflow;
   logic [15:0] drop_cnt;

   modport master (
      input  cmos_vsync, cmos_href, rgb565, rgb565_ready, fifo_full,
      output wr_en, wr_data, sof, eol, frame_done, overflow, drop_cnt
   );

   modport slave (
      output cmos_vsync, cmos_href, rgb565, rgb565_ready, fifo_full,
      input  wr_en, wr_data, sof, eol, frame_done, overflow, drop_cnt
   );
endinterface

// File: rtl/cmos_crop_packer.sv
// Crops the assembled RGB565 stream to a fixed window, packs pixel pairs into
// 32-bit words and writes them to the pixel FIFO, flagging sof/eol/overflow.
module cmos_crop_packer #(
   parameter int unsigned X_START = 0,
   parameter int unsigned Y_START = 0,
   parameter int unsigned WIN_W   = 640,
   parameter int unsigned WIN_H   = 480,
   parameter int unsigned CNT_W   = 12
) (
   input  logic                cmos_pclk,
   input  logic                rst_n,
   cmos_crop_packer_if.master  bus
);

   // Window bounds widened by one bit so X_START+WIN_W cannot wrap.
   localparam logic [CNT_W:0] XLo   = (CNT_W+1)'(X_START);
   localparam logic [CNT_W:0] XHi   = (CNT_W+1)'(X_START + WIN_W);
   localparam logic [CNT_W:0] XLast = (CNT_W+1)'(X_START + WIN_W - 1);
   localparam logic [CNT_W:0] YLo   = (CNT_W+1)'(Y_START);
   localparam logic [CNT_W:0] YHi   = (CNT_W+1)'(Y_START + WIN_H);

   typedef enum logic [0:0] {StWaitFrame, StInFrame} state_e;

   state_e             state_q, state_d;
   logic               vsync_q, vsync_d;
   logic               href_q, href_d;
   logic [CNT_W-1:0]   x_q, x_d;
   logic [CNT_W-1:0]   y_q, y_d;
   logic               half_q, half_d;
   logic [15:0]        low_q, low_d;
   logic               sof_pend_q, sof_pend_d;
   logic               wr_en_q, wr_en_d;
   logic [31:0]        wr_data_q, wr_data_d;
   logic               sof_q, sof_d;
   logic               eol_q, eol_d;
   logic               frame_done_q, frame_done_d;
   logic               overflow_q, overflow_d;
   logic [15:0]        drop_cnt_q, drop_cnt_d;

   logic               vs_fall, vs_rise, href_fall;
   logic               in_win;
   logic               issue;
   logic               word_eol;
   logic [31:0]        word;

   // Next-state: sync edges, window test, pairing, line flush and write issue.
   always_comb begin
      vs_fall   = vsync_q & ~bus.cmos_vsync;
      vs_rise   = ~vsync_q & bus.cmos_vsync;
      href_fall = href_q & ~bus.cmos_href;
      in_win    = ({1'b0, x_q} >= XLo) && ({1'b0, x_q} < XHi) &&
                  ({1'b0, y_q} >= YLo) && ({1'b0, y_q} < YHi);

      state_d      = state_q;
      vsync_d      = bus.cmos_vsync;
      href_d       = bus.cmos_href;
      x_d          = x_q;
      y_d          = y_q;
      half_d       = half_q;
      low_d        = low_q;
      sof_pend_d   = sof_pend_q;
      wr_en_d      = 1'b0;
      wr_data_d    = wr_data_q;
      sof_d        = 1'b0;
      eol_d        = 1'b0;
      frame_done_d = 1'b0;
      overflow_d   = overflow_q;
      drop_cnt_d   = drop_cnt_q;
      issue        = 1'b0;
      word_eol     = 1'b0;
      word         = '0;

      if (vs_fall) begin
         // Also taken while already in a frame: a vsync glitch restarts it.
         state_d    = StInFrame;
         x_d        = '0;
         y_d        = '0;
         half_d     = 1'b0;
         sof_pend_d = 1'b1;
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end else if (state_q == StInFrame) begin
         if (vs_rise) begin
            // Any pending half word is discarded.
            frame_done_d = 1'b1;
            state_d      = StWaitFrame;
            half_d       = 1'b0;
         end else begin
            // The pixel is processed first, with pre-increment x/y.
            if (bus.rgb565_ready) begin
               x_d = (x_q == '1) ? x_q : x_q + CNT_W'(1);
               if (in_win) begin
                  if (!half_q) begin
                     low_d  = bus.rgb565;
                     half_d = 1'b1;
                  end else begin
                     issue    = 1'b1;
                     word     = {bus.rgb565, low_q};
                     word_eol = ({1'b0, x_q} == XLast);
                     half_d   = 1'b0;
                  end
               end
            end
            if (href_fall) begin
               x_d = '0;
               y_d = (y_q == '1) ? y_q : y_q + CNT_W'(1);
               if (half_d) begin
                  issue    = 1'b1;
                  word     = {16'h0000, low_d};
                  word_eol = 1'b1;
                  half_d   = 1'b0;
               end else if (issue) begin
                  word_eol = 1'b1;
               end
            end
            if (issue) begin
               // sof belongs to the first issued word even if it is dropped.
               sof_pend_d = 1'b0;
               if (bus.fifo_full) begin
                  overflow_d = 1'b1;
                  drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
               end else begin
                  wr_en_d   = 1'b1;
                  wr_data_d = word;
                  sof_d     = sof_pend_q;
                  eol_d     = word_eol;
               end
            end
         end
      end
   end

   // State and registered outputs; sync copies reset so no edge fires at release.
   always_ff @(posedge cmos_pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StWaitFrame;
         vsync_q      <= 1'b1;
         href_q       <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         half_q       <= 1'b0;
         low_q        <= '0;
         sof_pend_q   <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_data_q    <= '0;
         sof_q        <= 1'b0;
         eol_q        <= 1'b0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         vsync_q      <= vsync_d;
         href_q       <= href_d;
         x_q          <= x_d;
         y_q          <= y_d;
         half_q       <= half_d;
         low_q        <= low_d;
         sof_pend_q   <= sof_pend_d;
         wr_en_q      <= wr_en_d;
         wr_data_q    <= wr_data_d;
         sof_q        <= sof_d;
         eol_q        <= eol_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign bus.wr_en      = wr_en_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.sof        = sof_q;
   assign bus.eol        = eol_q;
   assign bus.frame_done = frame_done_q;
   assign bus.overflow   = overflow_q;
   assign bus.drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_cmos_crop_packer.sv
// Bench for cmos_crop_packer: three differently-windowed instances share one
// stimulus stream; a frame-level model predicts every output cycle by cycle.
module tb_cmos_crop_packer;
   localparam int NDut   = 3;
   localparam int MaxCyc = 512;
   localparam int unsigned PXs [NDut] = '{4, 1, 2};
   localparam int unsigned PWw [NDut] = '{4, 3, 6};
   localparam int unsigned PYs [NDut] = '{2, 1, 1};
   localparam int unsigned PWh [NDut] = '{1, 2, 3};

   logic cmos_pclk = 1'b0;
   logic rst_n;
   always #5 cmos_pclk = ~cmos_pclk;

   logic        vs, hr, rdy, full;
   logic [15:0] pix;

   logic [NDut-1:0] o_wr, o_sof, o_eol, o_fd, o_ov;
   logic [31:0]     o_data [NDut];
   logic [15:0]     o_drop [NDut];

   for (genvar g = 0; g < NDut; g++) begin : g_dut
      cmos_crop_packer_if bus ();
      assign bus.cmos_vsync   = vs;
      assign bus.cmos_href    = hr;
      assign bus.rgb565       = pix;
      assign bus.rgb565_ready = rdy;
      assign bus.fifo_full    = full;
      assign o_wr[g]   = bus.wr_en;
      assign o_sof[g]  = bus.sof;
      assign o_eol[g]  = bus.eol;
      assign o_fd[g]   = bus.frame_done;
      assign o_ov[g]   = bus.overflow;
      assign o_data[g] = bus.wr_data;
      assign o_drop[g] = bus.drop_cnt;
      cmos_crop_packer #(
         .X_START (PXs[g]),
         .Y_START (PYs[g]),
         .WIN_W   (PWw[g]),
         .WIN_H   (PWh[g]),
         .CNT_W   (12)
      ) dut (
         .cmos_pclk (cmos_pclk),
         .rst_n     (rst_n),
         .bus       (bus)
      );
   end

   int total = 0;
   int bad   = 0;

   // Stimulus schedule for one frame.
   int          n_cyc, fall_cyc, rise_cyc;
   logic        s_vs [MaxCyc];
   logic        s_hr [MaxCyc];
   logic        s_rdy [MaxCyc];
   logic        s_full [MaxCyc];
   logic [15:0] s_pix [MaxCyc];
   int          st_cyc [$];
   int          st_line [$];
   int          st_x [$];
   logic [15:0] st_pix [$];
   int          ln_fall [$];

   // Model output: words issued by the packer (before the FIFO-full check).
   int          iss_cyc [$];
   logic [31:0] iss_word [$];
   logic        iss_eol [$];

   // Expected outputs per DUT per cycle.
   logic        e_wr [NDut][MaxCyc];
   logic        e_sof [NDut][MaxCyc];
   logic        e_eol [NDut][MaxCyc];
   logic        e_fd [NDut][MaxCyc];
   logic        e_ov [NDut][MaxCyc];
   logic [15:0] e_drop [NDut][MaxCyc];
   logic [31:0] e_data [NDut][MaxCyc];
   int          carry_drop [NDut];
   int          wr_count [NDut];

   task automatic push(input logic v, input logic h, input logic r, input logic [15:0] p);
      s_vs[n_cyc] = v; s_hr[n_cyc] = h; s_rdy[n_cyc] = r; s_pix[n_cyc] = p;
      s_full[n_cyc] = 1'b0;
      n_cyc++;
   endtask

   // One frame: blanking noise, vsync fall, lines of pixels, vsync rise.
   task automatic build_frame(input int lines, input int len, input bit fall_same,
                              input bit pix_is_x, input int abort_line, input int abort_px);
      n_cyc = 0;
      st_cyc.delete(); st_line.delete(); st_x.delete(); st_pix.delete(); ln_fall.delete();
      for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
      fall_cyc = n_cyc;
      for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b0, 16'h0);
      for (int l = 0; l < lines; l++) begin
         int npx;
         npx = (l == abort_line) ? abort_px : len;
         for (int p = 0; p < npx; p++) begin
            logic        last;
            logic [15:0] v;
            if ($urandom_range(0, 1) == 1) push(1'b0, 1'b1, 1'b0, 16'($urandom));
            last = (p == len - 1) && fall_same;
            v    = pix_is_x ? 16'(p) : 16'($urandom);
            st_cyc.push_back(n_cyc); st_line.push_back(l); st_x.push_back(p);
            st_pix.push_back(v);
            if (last) ln_fall.push_back(n_cyc);
            push(1'b0, !last, 1'b1, v);
         end
         if (l == abort_line) begin
            ln_fall.push_back(-1);
            break;
         end
         if (!fall_same) begin
            ln_fall.push_back(n_cyc);
            push(1'b0, 1'b0, 1'b0, 16'h0);
         end
         push(1'b0, 1'b0, 1'b0, 16'h0);
         push(1'b0, 1'b0, 1'b0, 16'h0);
      end
      rise_cyc = n_cyc;
      for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
   endtask

   // Kept pixels of each kept line pair up in arrival order; an odd one is
   // flushed zero-padded at line end. Nothing outside (vsync fall, vsync rise) counts.
   task automatic compute_issues(input int d);
      iss_cyc.delete(); iss_word.delete(); iss_eol.delete();
      for (int l = 0; l < ln_fall.size(); l++) begin
         logic [15:0] kept [$];
         if (l < int'(PYs[d]) || l >= int'(PYs[d] + PWh[d])) continue;
         for (int s = 0; s < st_cyc.size(); s++) begin
            if (st_line[s] != l || st_cyc[s] <= fall_cyc || st_cyc[s] >= rise_cyc) continue;
            if (st_x[s] < int'(PXs[d]) || st_x[s] >= int'(PXs[d] + PWw[d])) continue;
            kept.push_back(st_pix[s]);
            if (kept.size() % 2 == 0) begin
               iss_cyc.push_back(st_cyc[s]);
               iss_word.push_back({st_pix[s], kept[kept.size() - 2]});
               iss_eol.push_back((st_x[s] == int'(PXs[d] + PWw[d]) - 1) ||
                                 (st_cyc[s] == ln_fall[l]));
            end
         end
         if (kept.size() % 2 == 1 && ln_fall[l] >= 0 && ln_fall[l] < rise_cyc) begin
            iss_cyc.push_back(ln_fall[l]);
            iss_word.push_back({16'h0000, kept[kept.size() - 1]});
            iss_eol.push_back(1'b1);
         end
      end
   endtask

   task automatic fill_expect(input int d);
      int drops;
      int drop_at [MaxCyc];
      drops = 0;
      for (int i = 0; i < MaxCyc; i++) begin
         drop_at[i] = 0;
         e_wr[d][i] = 1'b0; e_sof[d][i] = 1'b0; e_eol[d][i] = 1'b0;
         e_fd[d][i] = (i == rise_cyc); e_data[d][i] = '0;
      end
      for (int k = 0; k < iss_cyc.size(); k++) begin
         int c;
         c = iss_cyc[k];
         if (s_full[c]) drop_at[c]++;
         else begin
            e_wr[d][c] = 1'b1; e_data[d][c] = iss_word[k];
            e_eol[d][c] = iss_eol[k]; e_sof[d][c] = (k == 0);
         end
      end
      for (int i = 0; i < MaxCyc; i++) begin
         if (i < fall_cyc) begin
            e_drop[d][i] = 16'(carry_drop[d]); e_ov[d][i] = (carry_drop[d] > 0);
         end else begin
            drops += drop_at[i];
            e_drop[d][i] = 16'(drops); e_ov[d][i] = (drops > 0);
         end
      end
      carry_drop[d] = drops;
   endtask

   task automatic fill_all();
      for (int d = 0; d < NDut; d++) begin
         compute_issues(d);
         fill_expect(d);
      end
   endtask

   task automatic set_full_random(input int pct);
      for (int i = 0; i < n_cyc; i++) s_full[i] = ($urandom_range(0, 99) < pct);
   endtask

   // Drive cycles [from,to) and compare each DUT one step after every edge.
   task automatic play(input int from, input int to);
      for (int i = from; i < to; i++) begin
         vs = s_vs[i]; hr = s_hr[i]; rdy = s_rdy[i]; pix = s_pix[i]; full = s_full[i];
         @(posedge cmos_pclk);
         #1;
         for (int d = 0; d < NDut; d++) begin
            logic [20:0] got, want;
            got  = {o_wr[d], o_sof[d], o_eol[d], o_fd[d], o_ov[d], o_drop[d]};
            want = {e_wr[d][i], e_sof[d][i], e_eol[d][i], e_fd[d][i], e_ov[d][i], e_drop[d][i]};
            total++;
            if (got !== want) begin
               bad++;
               $display("FAIL status cyc=%0d dut=%0d got wr/sof/eol/fd/ov/drop=%h want=%h",
                        i, d, got, want);
            end
            if (o_wr[d] && e_wr[d][i]) begin
               total++;
               if (o_data[d] !== e_data[d][i]) begin
                  bad++;
                  $display("FAIL wr_data cyc=%0d dut=%0d got=%h want=%h",
                           i, d, o_data[d], e_data[d][i]);
               end
            end
            if (o_wr[d]) wr_count[d]++;
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int d = 0; d < NDut; d++) begin
         logic [68:0] got;
         got = {o_wr[d], o_sof[d], o_eol[d], o_fd[d], o_ov[d], o_drop[d], o_data[d]};
         total++;
         if (got !== '0) begin
            bad++;
            $display("FAIL %s dut=%0d outputs got=%h want=0", tag, d, got);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; vs = 1'b1; hr = 1'b0; rdy = 1'b0; pix = '0; full = 1'b0;
      for (int d = 0; d < NDut; d++) begin carry_drop[d] = 0; wr_count[d] = 0; end
      repeat (3) @(posedge cmos_pclk);
      #1;
      check_all_zero("reset");
      @(negedge cmos_pclk);
      rst_n = 1'b1;
   endtask

   task automatic test_window();
      for (int d = 0; d < NDut; d++) wr_count[d] = 0;
      build_frame(4, 16, 1'b0, 1'b1, -1, 0);
      fill_all();
      play(0, n_cyc);
      total++;
      if (wr_count[0] != 2) begin
         bad++;
         $display("FAIL window_writes got=%0d want=2", wr_count[0]);
      end
   endtask

   task automatic test_odd_on_fall();
      build_frame(3, 4, 1'b1, 1'b0, -1, 0);
      fill_all();
      play(0, n_cyc);
   endtask

   task automatic test_overflow();
      build_frame(4, 14, 1'b0, 1'b0, -1, 0);
      compute_issues(2);
      for (int c = iss_cyc[1]; c <= iss_cyc[5]; c++) s_full[c] = 1'b1;
      fill_all();
      play(0, n_cyc);
      total++;
      if (o_drop[2] !== 16'd5 || o_ov[2] !== 1'b1) begin
         bad++;
         $display("FAIL overflow_hold drop_cnt=%0d overflow=%b want 5/1", o_drop[2], o_ov[2]);
      end
      // Clean frame: vsync fall clears both.
      build_frame(3, 10, 1'b0, 1'b0, -1, 0);
      fill_all();
      play(0, n_cyc);
   endtask

   task automatic test_reset_mid_line();
      int mid;
      build_frame(4, 12, 1'b0, 1'b0, -1, 0);
      fill_all();
      mid = st_cyc[st_cyc.size() / 2];
      play(0, mid);
      rst_n = 1'b0;
      #2;
      check_all_zero("async_reset");
      for (int d = 0; d < NDut; d++) begin
         carry_drop[d] = 0;
         for (int i = mid; i < MaxCyc; i++) begin
            e_wr[d][i] = 1'b0; e_sof[d][i] = 1'b0; e_eol[d][i] = 1'b0;
            e_fd[d][i] = 1'b0; e_ov[d][i] = 1'b0; e_drop[d][i] = '0;
         end
      end
      play(mid, n_cyc);
      @(negedge cmos_pclk);
      rst_n = 1'b1;
      build_frame(3, 10, 1'b0, 1'b0, -1, 0);
      fill_all();
      play(0, n_cyc);
   endtask

   task automatic test_vsync_abort();
      build_frame(4, 10, 1'b0, 1'b0, 2, 6);
      fill_all();
      play(0, n_cyc);
   endtask

   task automatic test_random_frames();
      for (int f = 0; f < 4; f++) begin
         build_frame(int'($urandom_range(3, 5)), int'($urandom_range(8, 12)),
                     1'($urandom_range(0, 1)), 1'b0, -1, 0);
         set_full_random(25);
         fill_all();
         play(0, n_cyc);
      end
   endtask

   initial begin
      test_reset();
      test_window();
      test_odd_on_fall();
      test_overflow();
      test_reset_mid_line();
      test_vsync_abort();
      test_random_frames();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
